// File: rtl/tcrc_gen_pkg.sv
// Shared types and constants for the serial CRC generator.
// Full-width polynomial support (CRC17/CRC21) is enabled by TCRC_GEN_FD_EN.
package tcrc_gen_pkg;

  localparam int CRC_WMAX = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CRC15 = 2'd0;
  localparam logic [1:0] MODE_CRC17 = 2'd1;
  localparam logic [1:0] MODE_CRC21 = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Polynomials with the implicit top bit dropped.
  localparam logic [CRC_WMAX-1:0] POLY_CRC15 = 21'h004599;
  localparam logic [CRC_WMAX-1:0] POLY_CRC17 = 21'h01685B;
  localparam logic [CRC_WMAX-1:0] POLY_CRC21 = 21'h102899;

  localparam logic [4:0] WIDTH_CRC15 = 5'd15;
  localparam logic [4:0] WIDTH_CRC17 = 5'd17;
  localparam logic [4:0] WIDTH_CRC21 = 5'd21;

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef TCRC_GEN_FD_EN
    return (m == MODE_RSVD) ? MODE_CRC15 : m;
`else
    return m & 2'b00;
`endif
  endfunction

  function automatic logic [4:0] width_of(input logic [1:0] m);
    case (m)
      MODE_CRC17: return WIDTH_CRC17;
      MODE_CRC21: return WIDTH_CRC21;
      default:    return WIDTH_CRC15;
    endcase
  endfunction

  function automatic logic [CRC_WMAX-1:0] poly_of(input logic [1:0] m);
    case (m)
      MODE_CRC17: return POLY_CRC17;
      MODE_CRC21: return POLY_CRC21;
      default:    return POLY_CRC15;
    endcase
  endfunction

  // A 21-bit width wraps 1<<21 to zero, so the subtraction still yields all ones.
  function automatic logic [CRC_WMAX-1:0] mask_of(input logic [1:0] m);
    return (CRC_WMAX'(1) << width_of(m)) - CRC_WMAX'(1);
  endfunction

  function automatic logic [CRC_WMAX-1:0] msb_of(input logic [1:0] m);
    return CRC_WMAX'(1) << (width_of(m) - 5'd1);
  endfunction

endpackage

// File: rtl/tcrc_gen_step.sv
// Combinational one-bit CRC advance; with fb_en low it is a plain masked left shift.
module tcrc_gen_step
  import tcrc_gen_pkg::*;
#(
  parameter int MAX_W = 21
) (
  input  logic [MAX_W-1:0] crc_cur,
  input  logic             bit_in,
  input  logic             fb_en,
  input  logic [1:0]       mode,
  output logic [MAX_W-1:0] crc_nxt
);

  logic [MAX_W-1:0] mask;
  logic [MAX_W-1:0] msb;
  logic [MAX_W-1:0] poly;
  logic             fb;

  assign mask = MAX_W'(mask_of(mode));
  assign msb  = MAX_W'(msb_of(mode));
  assign poly = MAX_W'(poly_of(mode));

  assign fb      = fb_en & (bit_in ^ (|(crc_cur & msb)));
  assign crc_nxt = ((crc_cur << 1) & mask) ^ (fb ? poly : '0);

endmodule

// File: rtl/tcrc_gen.sv
// Serial CRC generator: accumulate bits in CALC, then shift the result out MSB first.
// Define TCRC_GEN_FD_EN to enable CRC17/CRC21; otherwise every mode runs as CRC15.
//   state    | meaning
//   ST_IDLE  | waiting for load, steps ignored
//   ST_CALC  | each step folds bitin into the CRC
//   ST_SHIFT | each step shifts one CRC bit out on crc_tosend
//   ST_DONE  | one-cycle done pulse, then back to idle
module tcrc_gen
  import tcrc_gen_pkg::*;
#(
  parameter int MAX_W     = 21,
  parameter int STEP_EDGE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bitin,
  input  logic             activ,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [MAX_W-1:0] preload,
  input  logic             shft_out,
  input  logic             zerointcrc,
  output logic             crc_tosend,
  output logic [MAX_W-1:0] crc_val,
  output logic             busy,
  output logic             done
);

  if (MAX_W < 15 || MAX_W > CRC_WMAX) begin : g_range_chk
    $error("tcrc_gen: MAX_W must be within 15..21");
  end
`ifdef TCRC_GEN_FD_EN
  if (MAX_W < CRC_WMAX) begin : g_fd_chk
    $error("tcrc_gen: MAX_W must be 21 when CRC17/CRC21 are enabled");
  end
`endif

  state_t           state, state_nxt;
  logic [MAX_W-1:0] crc_q, crc_nxt;
  logic [4:0]       bitcnt, bitcnt_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic             activ_q;

  logic             step;
  logic [1:0]       mode_eff;
  logic [1:0]       mode_load;
  logic [MAX_W-1:0] load_mask;
  logic [MAX_W-1:0] msb_sel;
  logic [4:0]       bitcnt_init;
  logic             fb_en;
  logic             data_bit;
  logic [MAX_W-1:0] step_val;

  assign step = (STEP_EDGE != 0) ? (activ & ~activ_q) : activ;

  // mode is only sampled at load; everything after uses the latched copy.
  assign mode_eff    = eff_mode(mode_q);
  assign mode_load   = eff_mode(mode);
  assign load_mask   = MAX_W'(mask_of(mode_load));
  assign msb_sel     = MAX_W'(msb_of(mode_eff));
  assign bitcnt_init = width_of(mode_eff) - 5'd1;

  assign fb_en    = (state == ST_CALC);
  assign data_bit = bitin & zerointcrc;

  tcrc_gen_step #(
    .MAX_W (MAX_W)
  ) u_step (
    .crc_cur (crc_q),
    .bit_in  (data_bit),
    .fb_en   (fb_en),
    .mode    (mode_eff),
    .crc_nxt (step_val)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      crc_q   <= '0;
      bitcnt  <= '0;
      mode_q  <= MODE_CRC15;
      activ_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      crc_q   <= crc_nxt;
      bitcnt  <= bitcnt_nxt;
      mode_q  <= mode_nxt;
      activ_q <= activ;
    end
  end

  always_comb begin
    state_nxt  = state;
    crc_nxt    = crc_q;
    bitcnt_nxt = bitcnt;
    mode_nxt   = mode_q;
    if (load) begin
      crc_nxt   = preload & load_mask;
      mode_nxt  = mode;
      state_nxt = ST_CALC;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_CALC: begin
          // A coincident step is folded in before the transmission starts.
          if (step) begin
            crc_nxt = step_val;
          end
          if (shft_out) begin
            state_nxt  = ST_SHIFT;
            bitcnt_nxt = bitcnt_init;
          end
        end
        ST_SHIFT: begin
          if (step) begin
            crc_nxt = step_val;
            if (bitcnt == 5'd0) begin
              state_nxt = ST_DONE;
            end else begin
              bitcnt_nxt = bitcnt - 5'd1;
            end
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign crc_val    = crc_q;
  assign crc_tosend = |(crc_q & msb_sel);
  assign busy       = (state == ST_SHIFT);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_tcrc_gen.sv
// Directed bench for tcrc_gen: vector table of load+step results plus shift, edge and reset sequences.
module tb_tcrc_gen;
  import tcrc_gen_pkg::*;

  localparam int MAX_W = 21;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             bitin = 1'b0;
  logic             activ = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             load = 1'b0;
  logic [MAX_W-1:0] preload = '0;
  logic             shft_out = 1'b0;
  logic             zerointcrc = 1'b1;
  logic             crc_tosend;
  logic [MAX_W-1:0] crc_val;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  tcrc_gen #(
    .MAX_W     (MAX_W),
    .STEP_EDGE (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bitin      (bitin),
    .activ      (activ),
    .mode       (mode),
    .load       (load),
    .preload    (preload),
    .shft_out   (shft_out),
    .zerointcrc (zerointcrc),
    .crc_tosend (crc_tosend),
    .crc_val    (crc_val),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [20:0] pre;
    logic        bit_v;
    logic        gate;
    logic [20:0] exp_load;
    logic [20:0] exp_step;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic do_load(input logic [1:0] m, input logic [20:0] v);
    mode    = m;
    preload = v;
    load    = 1'b1;
    @(negedge clock);
    load    = 1'b0;
  endtask

  task automatic step_hi();
    activ = 1'b1;
    @(negedge clock);
  endtask

  task automatic step_lo();
    activ = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_step();
    step_hi();
    step_lo();
  endtask

  task automatic pulse_shft();
    shft_out = 1'b1;
    @(negedge clock);
    shft_out = 1'b0;
  endtask

  initial begin
    logic [14:0] exp_sh;

    vecs.push_back(vec_t'{"crc15_top",    2'd0, 21'h004000, 1'b0, 1'b1, 21'h4000, 21'h4599});
    vecs.push_back(vec_t'{"crc15_bit1",   2'd0, 21'h000000, 1'b1, 1'b1, 21'h0000, 21'h4599});
    vecs.push_back(vec_t'{"crc15_gated",  2'd0, 21'h000000, 1'b1, 1'b0, 21'h0000, 21'h0000});
    vecs.push_back(vec_t'{"crc15_shift",  2'd0, 21'h000001, 1'b0, 1'b1, 21'h0001, 21'h0002});
    vecs.push_back(vec_t'{"crc15_cancel", 2'd0, 21'h004001, 1'b1, 1'b1, 21'h4001, 21'h0002});
    vecs.push_back(vec_t'{"crc15_ones",   2'd0, 21'h007FFF, 1'b0, 1'b1, 21'h7FFF, 21'h3A67});
    vecs.push_back(vec_t'{"crc15_mask",   2'd0, 21'h1FFFFF, 1'b0, 1'b1, 21'h7FFF, 21'h3A67});
    vecs.push_back(vec_t'{"mode_rsvd",    2'd3, 21'h004000, 1'b0, 1'b1, 21'h4000, 21'h4599});
`ifdef TCRC_GEN_FD_EN
    vecs.push_back(vec_t'{"crc17_top",    2'd1, 21'h010000, 1'b0, 1'b1, 21'h10000, 21'h1685B});
    vecs.push_back(vec_t'{"crc21_top",    2'd2, 21'h100000, 1'b0, 1'b1, 21'h100000, 21'h102899});
`else
    vecs.push_back(vec_t'{"m2_as_crc15",  2'd2, 21'h004000, 1'b0, 1'b1, 21'h4000, 21'h4599});
    vecs.push_back(vec_t'{"m1_as_crc15",  2'd1, 21'h010000, 1'b0, 1'b1, 21'h0000, 21'h0000});
`endif

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_crc_val", 32'(crc_val), 32'h0);
    check("rst_tosend", 32'(crc_tosend), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Steps in IDLE do nothing
    bitin = 1'b1;
    do_step();
    check("idle_step_crc", 32'(crc_val), 32'h0);
    check("idle_shft_busy", 32'(busy), 32'h0);

    // Table: load then one CALC step
    foreach (vecs[i]) begin
      bitin      = vecs[i].bit_v;
      zerointcrc = vecs[i].gate;
      do_load(vecs[i].mode, vecs[i].pre);
      check({vecs[i].name, "_load"}, 32'(crc_val), 32'(vecs[i].exp_load));
      check({vecs[i].name, "_busy"}, 32'(busy), 32'h0);
      do_step();
      check({vecs[i].name, "_step"}, 32'(crc_val), 32'(vecs[i].exp_step));
    end
    zerointcrc = 1'b1;

    // Mode change after load has no effect
    bitin = 1'b0;
    do_load(2'd0, 21'h4000);
    mode = 2'd2;
    do_step();
    check("mode_hold", 32'(crc_val), 32'h4599);

    // Full 15-bit transmission
    do_load(2'd0, 21'h5555);
    pulse_shft();
    check("shift_busy0", 32'(busy), 32'h1);
    check("shift_tosend0", 32'(crc_tosend), 32'h1);
    check("shift_done0", 32'(done), 32'h0);
    for (int k = 1; k <= 15; k++) begin
      exp_sh = 15'h5555 << k;
      step_hi();
      check($sformatf("shift_val_%0d", k), 32'(crc_val), 32'(exp_sh));
      check($sformatf("shift_tosend_%0d", k), 32'(crc_tosend), 32'(exp_sh[14]));
      check($sformatf("shift_busy_%0d", k), 32'(busy), (k < 15) ? 32'h1 : 32'h0);
      check($sformatf("shift_done_%0d", k), 32'(done), (k < 15) ? 32'h0 : 32'h1);
      step_lo();
      check($sformatf("shift_done_lo_%0d", k), 32'(done), 32'h0);
    end
    check("shift_end_busy", 32'(busy), 32'h0);
    check("shift_end_state", 32'(dut.state), 32'(ST_IDLE));

    // shft_out with a coincident step: step applied first, then SHIFT
    do_load(2'd0, 21'h4000);
    bitin    = 1'b0;
    shft_out = 1'b1;
    activ    = 1'b1;
    @(negedge clock);
    shft_out = 1'b0;
    check("shft_step_val", 32'(crc_val), 32'h4599);
    check("shft_step_busy", 32'(busy), 32'h1);
    step_lo();

    // activ held high for 5 cycles yields one step
    do_load(2'd0, 21'h0001);
    bitin = 1'b0;
    activ = 1'b1;
    repeat (5) @(negedge clock);
    activ = 1'b0;
    @(negedge clock);
    check("edge_one_step", 32'(crc_val), 32'h0002);

    // load wins over a simultaneous step
    mode    = 2'd0;
    preload = 21'h0001;
    bitin   = 1'b1;
    load    = 1'b1;
    activ   = 1'b1;
    @(negedge clock);
    load = 1'b0;
    check("load_prio", 32'(crc_val), 32'h0001);
    repeat (2) @(negedge clock);
    check("load_prio_hold", 32'(crc_val), 32'h0001);
    step_lo();

    // Reset after the 7th SHIFT step
    bitin = 1'b0;
    do_load(2'd0, 21'h5555);
    pulse_shft();
    repeat (6) do_step();
    step_hi();
    exp_sh = 15'h5555 << 7;
    check("rst7_val", 32'(crc_val), 32'(exp_sh));
    check("rst7_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_crc", 32'(crc_val), 32'h0);
    check("rst_mid_tosend", 32'(crc_tosend), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clock);
    activ = 1'b0;
    check("rst_hold_done", 32'(done), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_rel_done", 32'(done), 32'h0);
    check("rst_rel_state", 32'(dut.state), 32'(ST_IDLE));
    pulse_shft();
    check("rst_rel_shft", 32'(busy), 32'h0);
    bitin = 1'b1;
    do_step();
    check("rst_rel_step", 32'(crc_val), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
